// File: rtl/usb_uart_tx.sv
// UART 8N1 transmitter for the USB debug status display.
// Pulls bytes from the annunciator via req/din/din_v and keeps one byte buffered ahead of the shifter.
module usb_uart_tx #(
    parameter int CLKS_PER_BIT = 417,
    parameter int FETCH_WAIT   = 4,
    parameter int STOP_BITS    = 1
) (
    input  logic       clk48,
    input  logic       rst,
    input  logic       enable,
    output logic       req,
    input  logic [7:0] din,
    input  logic       din_v,
    output logic       tx,
    output logic       busy
);

    localparam int WW = $clog2(FETCH_WAIT);
    localparam logic [WW-1:0] WAIT_LAST = WW'(FETCH_WAIT - 1);
    localparam logic [11:0]   BAUD_LAST = 12'(CLKS_PER_BIT - 1);
    localparam logic          STOP_LAST = 1'(STOP_BITS - 1);

    typedef enum logic [1:0] {F_IDLE, F_REQ, F_REL} fetch_state_e;
    typedef enum logic [1:0] {T_IDLE, T_START, T_DATA, T_STOP} tx_state_e;

    fetch_state_e    fstate_q, fstate_d;
    tx_state_e       tstate_q, tstate_d;
    logic [WW-1:0]   wait_cnt_q, wait_cnt_d;
    logic            req_q, req_d;
    logic [7:0]      hold_q, hold_d;
    logic            hold_full_q, hold_full_d;
    logic [11:0]     baud_q, baud_d;
    logic [2:0]      bit_idx_q, bit_idx_d;
    logic            stop_idx_q, stop_idx_d;
    logic [7:0]      shift_q, shift_d;
    logic            tx_q, tx_d;
    logic            busy_q, busy_d;
    logic            baud_done;

    always_comb begin
        fstate_d    = fstate_q;
        tstate_d    = tstate_q;
        wait_cnt_d  = wait_cnt_q;
        req_d       = req_q;
        hold_d      = hold_q;
        hold_full_d = hold_full_q;
        baud_d      = baud_q;
        bit_idx_d   = bit_idx_q;
        stop_idx_d  = stop_idx_q;
        shift_d     = shift_q;
        tx_d        = tx_q;
        baud_done   = (baud_q == BAUD_LAST);

        // Transmit side: consumes the holding buffer.
        case (tstate_q)
            T_IDLE: begin
                baud_d = '0;
                if (hold_full_q) begin
                    shift_d     = hold_q;
                    hold_full_d = 1'b0;
                    tstate_d    = T_START;
                    tx_d        = 1'b0;
                end
            end
            T_START: begin
                if (baud_done) begin
                    baud_d    = '0;
                    tstate_d  = T_DATA;
                    bit_idx_d = '0;
                    tx_d      = shift_q[0];
                    shift_d   = {1'b0, shift_q[7:1]};
                end else begin
                    baud_d = baud_q + 12'd1;
                end
            end
            T_DATA: begin
                if (baud_done) begin
                    baud_d = '0;
                    if (bit_idx_q == 3'd7) begin
                        tstate_d   = T_STOP;
                        stop_idx_d = 1'b0;
                        tx_d       = 1'b1;
                    end else begin
                        bit_idx_d = bit_idx_q + 3'd1;
                        tx_d      = shift_q[0];
                        shift_d   = {1'b0, shift_q[7:1]};
                    end
                end else begin
                    baud_d = baud_q + 12'd1;
                end
            end
            T_STOP: begin
                if (baud_done) begin
                    baud_d = '0;
                    if (stop_idx_q == STOP_LAST) begin
                        // A buffered byte starts immediately so frames stay back to back.
                        if (hold_full_q) begin
                            shift_d     = hold_q;
                            hold_full_d = 1'b0;
                            tstate_d    = T_START;
                            tx_d        = 1'b0;
                        end else begin
                            tstate_d = T_IDLE;
                        end
                    end else begin
                        stop_idx_d = 1'b1;
                    end
                end else begin
                    baud_d = baud_q + 12'd1;
                end
            end
            default: tstate_d = T_IDLE;
        endcase

        // Fetch side: only starts on an empty buffer, so its set never meets the clear above.
        case (fstate_q)
            F_IDLE: begin
                wait_cnt_d = '0;
                if (enable && !hold_full_q) begin
                    req_d    = 1'b1;
                    fstate_d = F_REQ;
                end
            end
            F_REQ: begin
                if (wait_cnt_q == WAIT_LAST) begin
                    if (din_v) begin
                        hold_d      = din;
                        hold_full_d = 1'b1;
                        req_d       = 1'b0;
                        fstate_d    = F_REL;
                        wait_cnt_d  = '0;
                    end
                end else begin
                    wait_cnt_d = wait_cnt_q + WW'(1);
                end
            end
            F_REL: begin
                // Two low cycles let the annunciator see inc fall before the next request.
                if (wait_cnt_q == WW'(1)) begin
                    fstate_d   = F_IDLE;
                    wait_cnt_d = '0;
                end else begin
                    wait_cnt_d = wait_cnt_q + WW'(1);
                end
            end
            default: fstate_d = F_IDLE;
        endcase

        busy_d = (tstate_d != T_IDLE) || hold_full_d;
    end

    always_ff @(posedge clk48) begin
        if (rst) begin
            fstate_q    <= F_IDLE;
            tstate_q    <= T_IDLE;
            wait_cnt_q  <= '0;
            req_q       <= 1'b0;
            hold_q      <= '0;
            hold_full_q <= 1'b0;
            baud_q      <= '0;
            bit_idx_q   <= '0;
            stop_idx_q  <= 1'b0;
            shift_q     <= '0;
            tx_q        <= 1'b1;
            busy_q      <= 1'b0;
        end else begin
            fstate_q    <= fstate_d;
            tstate_q    <= tstate_d;
            wait_cnt_q  <= wait_cnt_d;
            req_q       <= req_d;
            hold_q      <= hold_d;
            hold_full_q <= hold_full_d;
            baud_q      <= baud_d;
            bit_idx_q   <= bit_idx_d;
            stop_idx_q  <= stop_idx_d;
            shift_q     <= shift_d;
            tx_q        <= tx_d;
            busy_q      <= busy_d;
        end
    end

    assign req  = req_q;
    assign tx   = tx_q;
    assign busy = busy_q;

endmodule

// File: tb/tb_usb_uart_tx.sv
// Bench for usb_uart_tx: an annunciator model feeds bytes and queues them as expected,
// while a line monitor decodes tx frames and checks them against that queue.
module tb_usb_uart_tx;

    localparam int CPB   = 4;
    localparam int FW    = 4;
    localparam int FRAME = 10 * CPB;

    logic       clk48 = 1'b0;
    logic       rst = 1'b1;
    logic       enable = 1'b0;
    logic       req;
    logic [7:0] din;
    logic       din_v;
    logic       tx;
    logic       busy;

    always #5 clk48 = ~clk48;

    usb_uart_tx #(.CLKS_PER_BIT(CPB), .FETCH_WAIT(FW), .STOP_BITS(1)) dut (
        .clk48 (clk48),
        .rst   (rst),
        .enable(enable),
        .req   (req),
        .din   (din),
        .din_v (din_v),
        .tx    (tx),
        .busy  (busy)
    );

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    always @(posedge clk48) cyc <= cyc + 1;

    logic [7:0] exp_q[$];
    logic [7:0] src_q[$];
    int         fs_q[$];
    int  hold_off     = 1;
    int  cap_cnt      = 0;
    int  req_len      = 0;
    int  last_req_len = 0;
    int  cap_cyc      = 0;
    int  fall_cyc     = -100;
    int  req_rise_cnt = 0;
    bit  prev_req     = 1'b0;
    bit  mon_active   = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] want);
        total++;
        if (act !== want) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", name, act, want);
        end
    endtask

    // Annunciator model: presents the next byte while inc is high; a fall of inc is a capture.
    initial begin
        din   = 8'h00;
        din_v = 1'b0;
        forever begin
            @(negedge clk48);
            if (rst) begin
                prev_req = 1'b0;
                req_len  = 0;
                din_v    = 1'b0;
            end else begin
                if (req && !prev_req) begin
                    req_rise_cnt++;
                    check("req_gap", (cyc - fall_cyc) >= 3, 1);
                end
                if (req) begin
                    req_len++;
                    if (src_q.size() > 0 && req_len >= hold_off) begin
                        din   = src_q[0];
                        din_v = 1'b1;
                    end else begin
                        din_v = 1'b0;
                    end
                end else if (prev_req) begin
                    if (src_q.size() > 0) exp_q.push_back(src_q.pop_front());
                    last_req_len = req_len;
                    req_len      = 0;
                    cap_cnt++;
                    cap_cyc  = cyc;
                    fall_cyc = cyc;
                    din_v    = 1'b0;
                end
                prev_req = req;
            end
        end
    end

    // Line monitor: samples every cycle; each bit slot must hold one value for CPB cycles.
    initial begin
        int         mon_cyc;
        logic [9:0] slots;
        bit         stable;
        mon_cyc = 0;
        slots   = '0;
        stable  = 1'b1;
        forever begin
            @(negedge clk48);
            if (rst) begin
                mon_active = 1'b0;
            end else begin
                if (!mon_active && tx === 1'b0) begin
                    mon_active = 1'b1;
                    mon_cyc    = 0;
                    stable     = 1'b1;
                    fs_q.push_back(cyc);
                end
                if (mon_active) begin
                    if (mon_cyc % CPB == 0) slots[mon_cyc / CPB] = tx;
                    else if (tx !== slots[mon_cyc / CPB]) stable = 1'b0;
                    mon_cyc++;
                    if (mon_cyc == FRAME) begin
                        mon_active = 1'b0;
                        check("frame_fmt", {29'd0, stable, slots[0], slots[9]}, 32'b101);
                        if (exp_q.size() == 0) begin
                            total++;
                            bad++;
                            $display("FAIL frame_unexpected: got %0h want none", slots[8:1]);
                        end else begin
                            check("frame_data", {24'd0, slots[8:1]}, {24'd0, exp_q.pop_front()});
                        end
                    end
                end
            end
        end
    end

    task automatic reset_dut();
        @(negedge clk48);
        #1 rst = 1'b1;
        enable = 1'b0;
        repeat (2) @(negedge clk48);
        #1 rst = 1'b0;
        cap_cnt = 0;
        fs_q.delete();
    endtask

    task automatic wait_caps(input int n, input int budget);
        int k = 0;
        while (cap_cnt < n && k < budget) begin
            @(negedge clk48);
            #1 k++;
        end
        check("cap_wait", cap_cnt >= n, 1);
    endtask

    task automatic wait_frame_start(input int budget);
        int k = 0;
        while (fs_q.size() == 0 && k < budget) begin
            @(negedge clk48);
            #1 k++;
        end
        check("frame_start_wait", fs_q.size() > 0, 1);
    endtask

    task automatic wait_drain(input int budget);
        int k = 0;
        while ((exp_q.size() != 0 || mon_active) && k < budget) begin
            @(negedge clk48);
            #1 k++;
        end
        check("drain_wait", (exp_q.size() == 0) && !mon_active, 1);
    endtask

    initial begin
        int r0;
        // Reset with enable high: outputs idle during reset and on the first cycle after.
        enable = 1'b1;
        rst    = 1'b1;
        repeat (3) begin
            @(negedge clk48);
            check("rst_tx", tx, 1);
            check("rst_req", req, 0);
            check("rst_busy", busy, 0);
        end
        #1 rst = 1'b0;
        #2;
        check("post_rst_tx", tx, 1);
        check("post_rst_req", req, 0);
        check("post_rst_busy", busy, 0);
        @(negedge clk48);
        check("req_rise_latency", req, 1);

        // Single byte 0xA5.
        reset_dut();
        src_q = '{8'hA5};
        enable = 1'b1;
        wait_caps(1, 50);
        enable = 1'b0;
        check("single_req_len", last_req_len, 4);
        wait_frame_start(10);
        if (fs_q.size() > 0) check("tx_latency", fs_q[0] - cap_cyc, 1);
        repeat (5) @(negedge clk48);
        check("single_busy_mid", busy, 1);
        wait_drain(100);
        repeat (2) @(negedge clk48);
        check("single_idle_tx", tx, 1);
        check("single_idle_busy", busy, 0);
        check("single_caps", cap_cnt, 1);

        // Streaming three bytes back to back.
        reset_dut();
        src_q = '{8'h1B, 8'h5B, 8'h48};
        enable = 1'b1;
        wait_caps(2, 80);
        check("fetch2_in_frame1", (fs_q.size() > 0) && (cap_cyc < fs_q[0] + FRAME), 1);
        wait_caps(3, 120);
        enable = 1'b0;
        check("stream_req_len", last_req_len, 4);
        wait_drain(300);
        check("stream_frames", fs_q.size(), 3);
        for (int i = 1; i < fs_q.size(); i++) check("stream_gap", fs_q[i] - fs_q[i-1], FRAME);

        // din_v held low for 10 cycles past the fetch wait.
        reset_dut();
        src_q = '{8'hC3};
        hold_off = 15;
        enable = 1'b1;
        wait_caps(1, 60);
        enable = 1'b0;
        check("dv_low_req_len", last_req_len, 15);
        hold_off = 1;
        wait_drain(100);

        // Enable dropped mid-frame with the buffer full.
        reset_dut();
        src_q = '{8'h81, 8'h7E, 8'h55};
        enable = 1'b1;
        wait_caps(2, 60);
        enable = 1'b0;
        r0 = req_rise_cnt;
        check("drop_busy", busy, 1);
        wait_drain(200);
        repeat (3) @(negedge clk48);
        check("drop_tx", tx, 1);
        check("drop_busy_end", busy, 0);
        check("drop_no_req", req_rise_cnt - r0, 0);
        check("drop_frames", fs_q.size(), 2);
        check("drop_src_left", src_q.size(), 1);
        src_q.delete();

        // Reset during data bit 3 of 0xFF, then a clean frame.
        reset_dut();
        src_q = '{8'hFF};
        enable = 1'b1;
        wait_caps(1, 60);
        enable = 1'b0;
        wait_frame_start(10);
        repeat (17) @(negedge clk48);
        #1 rst = 1'b1;
        @(negedge clk48);
        check("rst_mid_tx", tx, 1);
        check("rst_mid_busy", busy, 0);
        check("rst_mid_pending", exp_q.size(), 1);
        exp_q.delete();
        #1 rst = 1'b0;
        fs_q.delete();
        cap_cnt = 0;
        src_q = '{8'h3C};
        enable = 1'b1;
        wait_caps(1, 60);
        enable = 1'b0;
        wait_drain(100);
        check("rst_mid_next_frames", fs_q.size(), 1);
        if (fs_q.size() > 0) check("rst_mid_latency", fs_q[0] - cap_cyc, 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/usb_uart_tx.md
# usb_uart_tx

Serial back end for the USB debug status display. It pulls bytes one at a time from the upstream annunciator using that block's `inc`/`dout`/`dout_v` handshake. It buffers one byte ahead and shifts each byte out as 8N1 UART on the debug TX pin. It runs continuously while enabled, so the annunciator's screen refresh streams to the host terminal without gaps beyond the configured stop bits.

## Interface
Parameters:
- `CLKS_PER_BIT`, default 417: clk48 cycles per UART bit (115200 baud); legal range 2..4095.
- `FETCH_WAIT`, default 4: cycles `req` is held high before `din` is sampled; minimum 3.
- `STOP_BITS`, default 1: stop bits per frame; 1 or 2.

Ports:
- `clk48`  in  1  48 MHz clock; all logic on its rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `enable`  in  1  permits new fetches; level-sensitive.
- `req`  out  1  fetch request; connects to annunciator `inc`.
- `din`  in  8  byte from annunciator `dout`.
- `din_v`  in  1  annunciator `dout_v`; qualifies the capture.
- `tx`  out  1  UART serial line; idle high.
- `busy`  out  1  high while a frame is shifting or the holding buffer is full.

## Operation
- Fetch FSM states: F_IDLE, F_REQ, F_REL.
  - F_IDLE: when `enable` && holding buffer empty, set `req`=1 and go to F_REQ. Clear the wait counter.
  - F_REQ: count to FETCH_WAIT-1. On the terminal count, if `din_v`=1, capture `din` into the holding buffer, set `hold_full`, drop `req`, and go to F_REL. If `din_v`=0, keep `req` high and stay in F_REQ, re-sampling each cycle.
  - F_REL: hold `req`=0 for exactly 2 cycles, then return to F_IDLE. This guarantees the upstream DONE→IDLE transition.
- TX FSM states: T_IDLE, T_START, T_DATA, T_STOP.
  - T_IDLE: if `hold_full`, load the shifter from the buffer, clear `hold_full` in the same cycle, and go to T_START.
  - T_START: drive `tx`=0 for one bit time.
  - T_DATA: drive 8 bits LSB first, using a 3-bit bit index.
  - T_STOP: drive `tx`=1 for STOP_BITS bit times. At the end, if `hold_full`, go directly to T_START with the new byte (back-to-back frames); otherwise go to T_IDLE.
- Holding-buffer handoff:
  - A clear by TX and a set by fetch in the same cycle is impossible, because fetch only starts when the buffer is empty.
  - Fetch of the next byte overlaps transmission of the current one.
- `enable` deasserted:
  - No new fetch starts.
  - An in-progress F_REQ/F_REL completes.
  - Every byte already captured is transmitted.
- Baud counter: 12 bits, counts 0..CLKS_PER_BIT-1, cleared on every state entry.
- `busy` = (TX state != T_IDLE) || `hold_full`.

## Timing
- Reset values: `req`=0, `tx`=1, `busy`=0, `hold_full`=0, both FSMs idle, all counters 0.
- `rst` mid-frame: on the next edge `tx`=1 and `req`=0, and the partially sent byte is discarded. Upstream reset is separate.
- Fetch latency: `req` rises 1 cycle after F_IDLE sees the conditions. With `din_v` high, the capture happens on the FETCH_WAIT-th cycle of `req` high. The next `req` rise is no earlier than 3 cycles after the fall.
- TX latency: the first `tx` falling edge appears 1 cycle after `hold_full` sets (TX idle).
- Every bit, including start and stop, is exactly CLKS_PER_BIT cycles.
- Frame length = (10 + STOP_BITS − 1) × CLKS_PER_BIT cycles. Back-to-back frames have no extra idle cycles.
- Outputs are registered and glitch-free; `tx` changes only at bit boundaries.

## Test plan
- Reset: assert `rst` 3 cycles with `enable`=1 → `tx`=1, `req`=0, `busy`=0 during reset and on the first cycle after it.
- Single byte, CLKS_PER_BIT=4, FETCH_WAIT=4:
  - Upstream model returns 0xA5 with `din_v`=1; drop `enable` after the first capture.
  - `tx` sequence: 0, then 1,0,1,0,0,1,0,1, then 1, each bit exactly 4 cycles.
  - `req` high for exactly 4 cycles.
- Streaming: bytes 0x1B, 0x5B, 0x48 with `enable` held high → three contiguous 40-cycle frames with no idle gap. The 2nd fetch completes during frame 1.
- `din_v` low: hold `din_v`=0 for 10 cycles after FETCH_WAIT expires → `req` stays high, no capture; the byte is captured on the first cycle `din_v`=1.
- `enable` drop: deassert mid-frame with the holding buffer full → both the current and buffered bytes are sent, then `tx`=1, `busy`=0, and `req` never rises again.
- Reset mid-frame: assert `rst` during bit 3 of 0xFF → `tx`=1 next cycle. After release, the next frame starts with a full-length start bit.
